btn_debounce_reader: RTL
========================

Name: btn_debounce_reader

Overview:
- Input-side companion to the LED blink driver: reads the iCEBreaker user buttons instead of driving the LEDs.
- Synchronises each button, debounces it, and normalises polarity to active-high.
- Produces clean pressed levels, one-cycle press/release pulses, and a wrapping press counter on the main button. The counter can feed LED1..LED5 directly.
- Sits between the raw button pads and any user logic in the top level.

Parameters:
- DEB_CYCLES, 12000, consecutive stable synchronised samples needed before a level change is accepted (1 ms at 12 MHz). Must be >= 2.
- CNT_W, 5, width of the press counter on the main button.

Ports:
- CLK  input  1  system clock (12 MHz board oscillator)
- RST_N  input  1  asynchronous active-low reset
- BTN_N  input  1  main user button, raw pad, active-low
- BTN1  input  1  breakout button 1, raw pad, active-high
- BTN2  input  1  breakout button 2, raw pad, active-high
- BTN3  input  1  breakout button 3, raw pad, active-high
- PRESSED  output  4  debounced level, active-high; bit0=BTN_N, bit1=BTN1, bit2=BTN2, bit3=BTN3
- PRESS_PULSE  output  4  one-cycle strobe when PRESSED[i] rises
- RELEASE_PULSE  output  4  one-cycle strobe when PRESSED[i] falls
- PRESS_CNT  output  CNT_W  count of accepted BTN_N presses, wraps

Behaviour:
- Reset is asynchronous on RST_N low and released synchronously on CLK.
- Reset values:
  - all synchroniser flops hold the released level (BTN_N path = 1, others = 0)
  - debounce counters = 0
  - PRESSED = 0, PRESS_PULSE = 0, RELEASE_PULSE = 0, PRESS_CNT = 0
- Polarity: BTN_N is inverted after synchronisation. All internal logic is active-high.
- Synchroniser: two flops per button (s1, s2), no combinational path from pad to any output.
- Debounce, per button, independent of the others; compares s2 with PRESSED[i] every cycle:
  - equal: counter <= 0
  - differ and counter < DEB_CYCLES-1: counter <= counter+1
  - differ and counter == DEB_CYCLES-1: PRESSED[i] <= s2, counter <= 0
- Counter width is clog2(DEB_CYCLES). The counter never exceeds DEB_CYCLES-1 and never wraps.
- Latency: a pad change ahead of edge k that then holds steady flips PRESSED on edge k+1+DEB_CYCLES.
- Glitch rejection: any s2 excursion shorter than DEB_CYCLES cycles resets the counter and produces no output change.
- Pulses are registered on the same edge that PRESSED[i] changes:
  - PRESS_PULSE[i]=1 for exactly one cycle on a 0->1 change
  - RELEASE_PULSE[i]=1 for exactly one cycle on a 1->0 change
  - PRESS and RELEASE pulses for the same bit are never high together.
- PRESS_CNT increments on the edge where PRESS_PULSE[0] is registered and becomes visible the cycle after the pulse. It wraps from 2^CNT_W-1 to 0 with no saturation.
- Simultaneous events: buttons are fully independent. Any combination of bits may pulse in the same cycle.
- Reset mid-bounce or mid-press:
  - everything returns to reset values immediately
  - after release, a still-held button is re-accepted after DEB_CYCLES+2 edges and produces a PRESS_PULSE; PRESS_CNT counts it.
- Only the BTN_N path drives PRESS_CNT.

Test Plan:
- DEB_CYCLES=4. Hold BTN1=1 from before edge 10 -> PRESSED[1]=1 and PRESS_PULSE[1]=1 on edge 15; pulse low from edge 16. No other bit moves.
- DEB_CYCLES=4. BTN_N bounces 0,1,0,1 at 1 cycle each, then settles at 0 -> no PRESS_PULSE during the bounce. Exactly one PRESS_PULSE[0] arrives 5 edges after the final settle; PRESS_CNT goes 0->1.
- BTN2 high for 3 cycles then low (DEB_CYCLES=4) -> PRESSED[2] stays 0 and no pulses occur. Repeat with 4 cycles high -> one press pulse, then one release pulse 4 cycles after s2 returns low.
- 33 clean BTN_N presses (CNT_W=5) -> PRESS_CNT passes 31 then reads 1. The wrap sequence 31->0->1 is observed.
- BTN1 and BTN3 pressed on the same edge -> PRESS_PULSE=4'b1010 on one cycle.
- BTN_N held low, RST_N pulsed low for 2 cycles mid-hold -> outputs clear asynchronously. Once RST_N returns high, PRESS_PULSE[0] reasserts 6 edges later and PRESS_CNT=1.

Source files
------------

// File: rtl/btn_debounce_reader.sv
// Button front end for the iCEBreaker: two-flop synchronisers, per-button debounce,
// active-high levels, one-cycle press/release strobes and a wrapping press counter.
module btn_debounce_reader #(
  parameter int DEB_CYCLES = 12000,
  parameter int CNT_W      = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BTN_N,
  input  logic             BTN1,
  input  logic             BTN2,
  input  logic             BTN3,
  output logic [3:0]       PRESSED,
  output logic [3:0]       PRESS_PULSE,
  output logic [3:0]       RELEASE_PULSE,
  output logic [CNT_W-1:0] PRESS_CNT
);

  localparam int            DW       = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  // Raw pad levels while released: BTN_N idles high, breakout buttons idle low.
  localparam logic [3:0]    IDLE_RAW = 4'b0001;

  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    lvl;
  logic [DW-1:0] deb_cnt [4];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= IDLE_RAW;
      s2 <= IDLE_RAW;
    end else begin
      s1 <= {BTN3, BTN2, BTN1, BTN_N};
      s2 <= s1;
    end
  end

  assign lvl = s2 ^ IDLE_RAW;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
      PRESSED       <= '0;
      PRESS_PULSE   <= '0;
      RELEASE_PULSE <= '0;
    end else begin
      PRESS_PULSE   <= '0;
      RELEASE_PULSE <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (lvl[i] == PRESSED[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != DEB_LAST) begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end else begin
          deb_cnt[i]       <= '0;
          PRESSED[i]       <= lvl[i];
          PRESS_PULSE[i]   <= lvl[i];
          RELEASE_PULSE[i] <= ~lvl[i];
        end
      end
    end
  end

  // Counts off the registered strobe, so the new value appears the cycle after the pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PRESS_CNT <= '0;
    end else if (PRESS_PULSE[0]) begin
      PRESS_CNT <= PRESS_CNT + CNT_W'(1);
    end
  end

endmodule
